// File: rtl/stopwatch_ctrl_if.sv
// Front-panel bundle for the stopwatch: 100 Hz strobe and buttons in, BCD digits and status out.
interface stopwatch_ctrl_if;
  logic       clk_100;
  logic       btn_start;
  logic       btn_lap;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] cs_tens;
  logic [3:0] cs_ones;
  logic       running;
  logic       lap_active;

  modport master (
    output clk_100, btn_start, btn_lap,
    input  sec_tens, sec_ones, cs_tens, cs_ones, running, lap_active
  );

  modport slave (
    input  clk_100, btn_start, btn_lap,
    output sec_tens, sec_ones, cs_tens, cs_ones, running, lap_active
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: edge-detected 100 Hz tick and buttons drive an IDLE/RUN/PAUSE/LAP FSM
// over a 4-digit BCD count (ss.cc). Define STOPWATCH_LAP_EN to build the LAP state and snapshot.
module stopwatch_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  stopwatch_ctrl_if.slave sw
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
`ifdef STOPWATCH_LAP_EN
  localparam logic [1:0] ST_LAP   = 2'd3;
`endif

  // Digits packed as {sec_tens, sec_ones, cs_tens, cs_ones}; 59.99 wraps to 00.00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = (v[15:12] == 4'd5) ? 4'd0 : v[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  logic        clk_100_q;
  logic        btn_start_q;
  logic        btn_lap_q;
  logic        tick;
  logic        start_ev;
  logic        lap_ev;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        clr_cnt;
  logic        snap_ld;
  logic        counting;
  logic [15:0] count;
  logic [15:0] display;

  // Button delay flops reset high so a button held through reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_100_q   <= 1'b0;
      btn_start_q <= 1'b1;
      btn_lap_q   <= 1'b1;
    end else begin
      clk_100_q   <= sw.clk_100;
      btn_start_q <= sw.btn_start;
      btn_lap_q   <= sw.btn_lap;
    end
  end

  assign tick     = sw.clk_100   & ~clk_100_q;
  assign start_ev = sw.btn_start & ~btn_start_q;
  assign lap_ev   = sw.btn_lap   & ~btn_lap_q;

  // start_ev is tested first in every state, so it wins over a same-cycle lap_ev.
  always_comb begin
    state_nxt = state;
    clr_cnt   = 1'b0;
    snap_ld   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ev) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (start_ev) begin
          state_nxt = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
        end else if (lap_ev) begin
          state_nxt = ST_LAP;
          snap_ld   = 1'b1;
`endif
        end
      end
`ifdef STOPWATCH_LAP_EN
      ST_LAP: begin
        if (start_ev)    state_nxt = ST_PAUSE;
        else if (lap_ev) state_nxt = ST_RUN;
      end
`endif
      ST_PAUSE: begin
        if (start_ev) begin
          state_nxt = ST_RUN;
        end else if (lap_ev) begin
          state_nxt = ST_IDLE;
          clr_cnt   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Counting follows the current registered state, so the exit cycle from RUN/LAP still counts.
`ifdef STOPWATCH_LAP_EN
  assign counting = (state == ST_RUN) || (state == ST_LAP);
`else
  assign counting = (state == ST_RUN);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                count <= 16'h0000;
    else if (clr_cnt)          count <= 16'h0000;
    else if (tick && counting) count <= bcd_inc(count);
  end

`ifdef STOPWATCH_LAP_EN
  logic [15:0] snap;

  // Snapshot takes the pre-increment value when a tick lands on the lap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       snap <= 16'h0000;
    else if (snap_ld) snap <= count;
  end

  assign display       = (state == ST_LAP) ? snap : count;
  assign sw.lap_active = (state == ST_LAP);
  assign sw.running    = (state == ST_RUN) || (state == ST_LAP);
`else
  assign display       = count;
  assign sw.lap_active = 1'b0;
  assign sw.running    = (state == ST_RUN);
`endif

  assign sw.sec_tens = display[15:12];
  assign sw.sec_ones = display[11:8];
  assign sw.cs_tens  = display[7:4];
  assign sw.cs_ones  = display[3:0];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed scoreboard bench for stopwatch_ctrl; expectations follow STOPWATCH_LAP_EN when defined.
module tb_stopwatch_ctrl;

  logic clk;
  logic rst_n;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw_if.slave)
  );

  typedef struct {
    string       name;
    logic [15:0] digits;
    logic        run;
    logic        lap;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares the oldest pending expectation against the outputs on the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] act;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      act = {sw_if.sec_tens, sw_if.sec_ones, sw_if.cs_tens, sw_if.cs_ones};
      checks++;
      if (act !== e.digits || sw_if.running !== e.run || sw_if.lap_active !== e.lap) begin
        failures++;
        $display("FAIL %s: got %h.%h running=%b lap_active=%b, expected %h.%h running=%b lap_active=%b",
                 e.name, act[15:8], act[7:0], sw_if.running, sw_if.lap_active,
                 e.digits[15:8], e.digits[7:0], e.run, e.lap);
      end
    end
  end

  task automatic expect_out(input string name, input logic [15:0] d, input logic r, input logic l);
    exp_t e;
    int   waited;
    e.name   = name;
    e.digits = d;
    e.run    = r;
    e.lap    = l;
    sb.push_back(e);
    waited = 0;
    while (sb.size() != 0 && waited < 8) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: monitor did not consume expectation within 8 cycles", name);
      sb.delete();
    end
  endtask

  // One cycle with the given inputs raised, then all return low.
  task automatic press(input logic s, input logic l, input logic t);
    @(posedge clk);
    #1;
    sw_if.btn_start = s;
    sw_if.btn_lap   = l;
    sw_if.clk_100   = t;
    @(posedge clk);
    #1;
    sw_if.btn_start = 1'b0;
    sw_if.btn_lap   = 1'b0;
    sw_if.clk_100   = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) press(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    sw_if.btn_start = 1'b1;
    sw_if.btn_lap   = 1'b0;
    sw_if.clk_100   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset_state", 16'h0000, 1'b0, 1'b0);

    // Start button held high through reset release must not start the watch.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_out("held_start_idle", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    sw_if.btn_start = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    expect_out("start_run", 16'h0000, 1'b1, 1'b0);
    tick_n(150);
    expect_out("count_01_50", 16'h0150, 1'b1, 1'b0);

    tick_n(3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    expect_out("reset_mid_run", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    press(1'b1, 1'b0, 1'b0);
    expect_out("restart_run", 16'h0000, 1'b1, 1'b0);

    tick_n(5998);
    expect_out("preload_59_98", 16'h5998, 1'b1, 1'b0);
    tick_n(1);
    expect_out("count_59_99", 16'h5999, 1'b1, 1'b0);
    tick_n(1);
    expect_out("wrap_00_00", 16'h0000, 1'b1, 1'b0);

    tick_n(42);
    expect_out("run_00_42", 16'h0042, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    expect_out("lap_press", 16'h0042, 1'b1, LAP_EN);
    tick_n(10);
    expect_out("lap_10_ticks", LAP_EN ? 16'h0042 : 16'h0052, 1'b1, LAP_EN);
    press(1'b0, 1'b1, 1'b0);
    expect_out("lap_release_00_52", 16'h0052, 1'b1, 1'b0);

    press(1'b0, 1'b1, 1'b1);
    expect_out("lap_with_tick", LAP_EN ? 16'h0052 : 16'h0053, 1'b1, LAP_EN);
    press(1'b0, 1'b1, 1'b0);
    expect_out("lap_back_live", 16'h0053, 1'b1, 1'b0);

    press(1'b1, 1'b1, 1'b0);
    expect_out("start_lap_same_cycle", 16'h0053, 1'b0, 1'b0);
    tick_n(4);
    expect_out("pause_hold", 16'h0053, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    expect_out("resume_no_inc", 16'h0053, 1'b1, 1'b0);
    tick_n(254);
    expect_out("run_03_07", 16'h0307, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    expect_out("pause_03_07", 16'h0307, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    expect_out("pause_lap_clear", 16'h0000, 1'b0, 1'b0);
    tick_n(5);
    expect_out("idle_ticks_hold", 16'h0000, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    expect_out("idle_lap_ignored", 16'h0000, 1'b0, 1'b0);

    press(1'b1, 1'b0, 1'b0);
    tick_n(1);
    expect_out("run_00_01", 16'h0001, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    tick_n(2);
    expect_out("lap_live_advances", LAP_EN ? 16'h0001 : 16'h0003, 1'b1, LAP_EN);
    press(1'b1, 1'b0, 1'b0);
    expect_out("lap_to_pause_live", 16'h0003, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
